// File: rtl/booth_multiplier_10bit.sv
// Sequential signed radix-2 Booth multiplier: WIDTH iterations of add/sub then arithmetic shift right.
// Optional zero-operand early completion when BOOTH_ZERO_SKIP_EN is defined.
module booth_multiplier_10bit #(
    parameter int WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WIDTH - 1);

    state_t                    state_q, state_d;
    logic signed [WIDTH:0]     m_q, m_d;
    logic signed [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]          q_q, q_d;
    logic                      qm1_q, qm1_d;
    logic [3:0]                count_q, count_d;
    logic [2*WIDTH-1:0]        product_q, product_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [WIDTH:0]     acc_sum;
    logic [2*WIDTH+1:0]        shifted;
    logic                      zero_op;

    // One-bit arithmetic right shift of the combined {acc, q, q_m1} register.
    function automatic logic [2*WIDTH+1:0] asr1(input logic [2*WIDTH+1:0] v);
        return {v[2*WIDTH+1], v[2*WIDTH+1:1]};
    endfunction

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q - m_q;
            default: acc_sum = acc_q;
        endcase
        shifted = asr1({acc_sum, q_q, qm1_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = zero_op ? DONE : RUN;
            RUN:     if (count_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered status outputs follow the next state so busy/done are glitch-free flops.
    always_comb begin
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    acc_d   = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    count_d = '0;
                    if (zero_op) product_d = '0;
                end
            end
            RUN: begin
                acc_d   = shifted[2*WIDTH+1:WIDTH+1];
                q_d     = shifted[WIDTH:1];
                qm1_d   = shifted[0];
                count_d = count_q + 4'd1;
                if (count_q == LAST) product_d = shifted[2*WIDTH:1];
            end
            default: ;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier_10bit.sv
// Directed testbench for booth_multiplier_10bit with hand-computed products.
module tb_booth_multiplier_10bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  multiplicand = '0;
    logic [9:0]  multiplier = '0;
    logic        busy;
    logic        done;
    logic [19:0] product;

    int vectors = 0;
    int miscompares = 0;

    booth_multiplier_10bit dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [9:0] a, input logic [9:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 10'($urandom);
        multiplier   = 10'($urandom);
    endtask

    // Observes from the first negedge after the accepting edge until done or a 40-cycle bound.
    task automatic wait_done(output int busy_cyc, output int done_at, output bit overlap);
        busy_cyc = 0;
        done_at  = 0;
        overlap  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy && done) overlap = 1'b1;
            if (busy) busy_cyc++;
            if (done) begin
                done_at = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (product !== 20'h0) begin miscompares++; $display("FAIL reset_product: got %h expected 00000", product); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int bc, da; bit ov;
        do_start(10'd3, 10'd5);
        wait_done(bc, da, ov);
        vectors++; if (bc !== 10) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 10", bc); end
        vectors++; if (da !== 11) begin miscompares++; $display("FAIL basic_done_cycle: got %0d expected 11", da); end
        vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL basic_busy_done_overlap: got %b expected 0", ov); end
        vectors++; if (product !== 20'h0000F) begin miscompares++; $display("FAIL basic_product: got %h expected 0000f", product); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        repeat (3) @(negedge clk);
        vectors++; if (product !== 20'h0000F) begin miscompares++; $display("FAIL basic_hold: got %h expected 0000f", product); end
    endtask

    task automatic test_extremes();
        int bc, da; bit ov;
        do_start(10'h200, 10'h200);
        wait_done(bc, da, ov);
        vectors++; if (product !== 20'h40000) begin miscompares++; $display("FAIL neg512_sq: got %h expected 40000", product); end
        do_start(10'h200, 10'h1FF);
        wait_done(bc, da, ov);
        vectors++; if (product !== 20'hC0200) begin miscompares++; $display("FAIL neg512_x_511: got %h expected c0200", product); end
        vectors++; if (da !== 11) begin miscompares++; $display("FAIL neg512_x_511_done_cycle: got %0d expected 11", da); end
    endtask

    task automatic test_back_to_back();
        int bc, da; bit ov;
        do_start(10'h3FF, 10'h1FF);
        wait_done(bc, da, ov);
        vectors++; if (product !== 20'hFFE01) begin miscompares++; $display("FAIL neg1_x_511: got %h expected ffe01", product); end
        do_start(10'd7, 10'h3F8);
        wait_done(bc, da, ov);
        vectors++; if (da !== 11) begin miscompares++; $display("FAIL b2b_done_cycle: got %0d expected 11", da); end
        vectors++; if (product !== 20'hFFFC8) begin miscompares++; $display("FAIL b2b_7_x_neg8: got %h expected fffc8", product); end
    endtask

    task automatic test_ignored_start();
        int bc, da; bit ov;
        bit activity;
        do_start(10'd12, 10'h3DE);
        @(negedge clk);
        @(negedge clk);
        multiplicand = 10'd100;
        multiplier   = 10'd100;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, da, ov);
        vectors++; if (da !== 8) begin miscompares++; $display("FAIL restart_run_done_cycle: got %0d expected 8", da); end
        vectors++; if (product !== 20'hFFE68) begin miscompares++; $display("FAIL restart_run_product: got %h expected ffe68", product); end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        activity = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || done) activity = 1'b1;
        end
        vectors++; if (activity !== 1'b0) begin miscompares++; $display("FAIL restart_done_ignored: got %b expected 0", activity); end
        vectors++; if (product !== 20'hFFE68) begin miscompares++; $display("FAIL restart_done_hold: got %h expected ffe68", product); end
    endtask

    task automatic test_reset_mid_run();
        int bc, da; bit ov;
        bit activity;
        do_start(10'd3, 10'd5);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b expected 0", done); end
        vectors++; if (product !== 20'h0) begin miscompares++; $display("FAIL midrst_product: got %h expected 00000", product); end
        @(negedge clk);
        rst = 1'b0;
        activity = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || done) activity = 1'b1;
        end
        vectors++; if (activity !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done: got %b expected 0", activity); end
        do_start(10'd2, 10'd3);
        wait_done(bc, da, ov);
        vectors++; if (product !== 20'h00006) begin miscompares++; $display("FAIL midrst_then_2x3: got %h expected 00006", product); end
    endtask

    task automatic test_zero();
        int bc, da; bit ov;
        int exp_bc, exp_da;
`ifdef BOOTH_ZERO_SKIP_EN
        exp_bc = 0;
        exp_da = 1;
`else
        exp_bc = 10;
        exp_da = 11;
`endif
        do_start(10'd0, 10'd123);
        wait_done(bc, da, ov);
        vectors++; if (bc !== exp_bc) begin miscompares++; $display("FAIL zero_busy_cycles: got %0d expected %0d", bc, exp_bc); end
        vectors++; if (da !== exp_da) begin miscompares++; $display("FAIL zero_done_cycle: got %0d expected %0d", da, exp_da); end
        vectors++; if (product !== 20'h0) begin miscompares++; $display("FAIL zero_product: got %h expected 00000", product); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_run();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_10bit.md
Name: booth_multiplier_10bit

Overview:
- Sequential signed radix-2 Booth multiplier for the 10-bit two's-complement datapath.
- Each iteration has two steps: an add/subtract of the multiplicand into the accumulator, then a one-bit arithmetic right shift of the combined {acc, multiplier, q_m1} register.
- This block is the consumer of the 10-bit arithmetic-right-shift stage and sequences it once per cycle.
- Produces a 20-bit signed product after 10 iterations, with a start/busy/done handshake.

Parameters:
- WIDTH, 10, operand width in bits. Product is 2*WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- multiplicand  input  WIDTH  signed operand M; captured on the accepting edge
- multiplier  input  WIDTH  signed operand Q; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  signed result; registered and held until the next completion

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, busy=0, done=0, product=0.
  - All internal registers cleared: acc, q, q_m1, m, count.
- Internal registers:
  - m: WIDTH+1 bits, sign-extended multiplicand.
  - acc: WIDTH+1 bits. The extra bit prevents overflow when M=-512 is subtracted.
  - q: WIDTH bits.
  - q_m1: 1 bit.
  - count: 4 bits.
- State IDLE:
  - start=1 at an edge → load m=sext(M), acc=0, q=Q, q_m1=0, count=0; go to RUN.
  - start=0 → stay in IDLE.
- State RUN (busy=1): each edge performs one iteration.
  - {q[0],q_m1}=01 → acc_n = acc + m.
  - {q[0],q_m1}=10 → acc_n = acc - m.
  - 00 or 11 → acc_n = acc.
  - Then arithmetic shift right by 1 of {acc_n,q,q_m1}: the MSB of acc_n is replicated, and the old q[0] moves into q_m1.
  - count increments. On the edge completing iteration WIDTH (count=WIDTH-1), go to DONE.
  - On that same edge, product <= {acc_n_shifted[WIDTH-1:0], q_shifted}.
- State DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge → IDLE unconditionally.
  - start asserted during DONE is ignored.
- Latency:
  - The accepting edge is E0.
  - done is high during the cycle following edge E0+WIDTH (10 RUN edges).
  - Minimum start-to-start spacing is 12 cycles.
- start while busy (RUN): ignored; operands are not re-captured.
- Operand inputs may change freely after the accepting edge.
- product holds its last value through IDLE and RUN. It updates only on the edge entering DONE.
- Arithmetic: all signed two's complement.
  - Full range is exact, including -512 × -512 = +262144 (0x40000).
  - Result fits in 20 bits. No overflow or saturation is possible.
- Reset mid-operation: aborts immediately. Outputs return to reset values. No done pulse for the aborted operation.
- done and busy are never high together. Both are registered outputs.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined:
  - If multiplicand==0 or multiplier==0 on the accepting edge, go directly from IDLE to DONE with product <= 0.
  - done is high in the cycle after E0, and busy is never asserted.
  - Nonzero operands behave exactly as in the base design.
- Undefined:
  - Zero operands take the full 10-iteration path.
  - done arrives after E0+10 and product=0.

Test Plan:
- 3 × 5, start one cycle → busy high for 10 cycles, then done pulse with product=15 (0x0000F); product holds afterwards.
- -512 × -512 → product=0x40000. Also -512 × 511 → product=-261632 (0xC0200).
- -1 × 511 → 0xFFE01. Then back-to-back 7 × -8 started in the IDLE cycle right after done → 0xFFFC8.
- start re-pulsed with new operands (100, 100) mid-RUN and again during the DONE cycle → both ignored; first result completes unchanged. A fresh start is needed for a second result.
- rst asserted at RUN iteration 5 → busy=0, done=0 and product=0 asynchronously; no done pulse after release. A new 2 × 3 then yields 6.
- 0 × 123 with BOOTH_ZERO_SKIP_EN defined → done one cycle after the accepting edge, busy never high, product=0. Without the macro → done after 10 busy cycles, product=0.
